// File: rtl/addsub_serial_pkg.sv
// Shared constants for the digit-serial add/subtract unit.
//   - FSM state encodings (IDLE, RUN, DONE)
//   - Mode encodings (MODE_SUB, MODE_ADD)
//   - cntWidth(): digit counter width, never narrower than one bit
package addsub_serial_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_ADD = 1'b1;

    // A single-digit configuration still needs a one-bit counter.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// One DIGIT-bit slice of the serial adder/subtractor, built as a ripple of full cells.
// Ports:
//   a, b  : operand digits
//   cIn   : carry-in (add) or borrow-in (sub)
//   mode  : MODE_ADD or MODE_SUB
//   res   : result digit
//   cOut  : carry-out (add) or borrow-out (sub) of the slice
//   cMsb  : carry/borrow into the slice's top bit (for signed overflow)
module addsub_digit
    import addsub_serial_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cIn,
    input  logic             mode,
    output logic [DIGIT-1:0] res,
    output logic             cOut,
    output logic             cMsb
);

    // Subtraction runs as a + ~b + ~borrow; borrows are the inverted internal carries.
    always_comb begin
        logic [DIGIT:0]   c;
        logic [DIGIT-1:0] bEff;
        logic             isAdd;
        isAdd = (mode == MODE_ADD);
        bEff  = isAdd ? b : ~b;
        c     = '0;
        res   = '0;
        c[0]  = isAdd ? cIn : ~cIn;
        for (int i = 0; i < DIGIT; i++) begin
            res[i]   = a[i] ^ bEff[i] ^ c[i];
            c[i + 1] = (a[i] & bEff[i]) | (c[i] & (a[i] ^ bEff[i]));
        end
        cOut = isAdd ? c[DIGIT] : ~c[DIGIT];
        cMsb = isAdd ? c[DIGIT-1] : ~c[DIGIT-1];
    end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial add/subtract unit with start/done/ack handshake.
// Processes DIGIT bits per clock; a WIDTH-bit operation takes WIDTH/DIGIT RUN cycles.
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   startIn         : operation request, sampled in IDLE only
//   modeIn          : 0 = a-b-crIn, 1 = a+b+crIn
//   aIn, bIn, crIn  : operands and carry/borrow-in, latched on the start edge
//   readyOut        : high in IDLE
//   diffOut, brw    : registered result and carry/borrow-out
//   ovfOut          : registered signed overflow
//   doneOut         : result valid, held until ackIn
//   ackIn           : result accepted, sampled in DONE only
module addsub_serial
    import addsub_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startIn,
    input  logic             modeIn,
    input  logic [WIDTH-1:0] aIn,
    input  logic [WIDTH-1:0] bIn,
    input  logic             crIn,
    output logic             readyOut,
    output logic [WIDTH-1:0] diffOut,
    output logic             brw,
    output logic             ovfOut,
    output logic             doneOut,
    input  logic             ackIn
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = cntWidth(NDIG);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] aSh;
    logic [WIDTH-1:0] bSh;
    logic [WIDTH-1:0] resSh;
    logic             modeQ;
    logic             carryQ;

    logic [DIGIT-1:0] digRes;
    logic             digC;
    logic             digMsb;
    logic [WIDTH-1:0] resNext;
    logic             lastDig;

    addsub_digit #(
        .DIGIT (DIGIT)
    ) uDigit (
        .a    (aSh[DIGIT-1:0]),
        .b    (bSh[DIGIT-1:0]),
        .cIn  (carryQ),
        .mode (modeQ),
        .res  (digRes),
        .cOut (digC),
        .cMsb (digMsb)
    );

    // New digit enters at the MSB end; written as shifts so DIGIT == WIDTH needs no special case.
    assign resNext  = (resSh >> DIGIT) | (WIDTH'(digRes) << (WIDTH - DIGIT));
    assign lastDig  = (cnt == CW'(NDIG - 1));
    assign readyOut = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            aSh     <= '0;
            bSh     <= '0;
            resSh   <= '0;
            modeQ   <= MODE_SUB;
            carryQ  <= 1'b0;
            diffOut <= '0;
            brw     <= 1'b0;
            ovfOut  <= 1'b0;
            doneOut <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (startIn) begin
                        aSh    <= aIn;
                        bSh    <= bIn;
                        modeQ  <= modeIn;
                        carryQ <= crIn;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    aSh    <= aSh >> DIGIT;
                    bSh    <= bSh >> DIGIT;
                    resSh  <= resNext;
                    carryQ <= digC;
                    cnt    <= cnt + CW'(1);
                    if (lastDig) begin
                        diffOut <= resNext;
                        brw     <= digC;
                        // Carry into bit WIDTH-1 vs. carry out of it; borrow inversion cancels.
                        ovfOut  <= digMsb ^ digC;
                        doneOut <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (ackIn) begin
                        doneOut <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench: five configurations run side by side, each against a
// cycle-level behavioural model computed with plain integer arithmetic.
module tb_addsub_serial;

    logic clk;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cfgW(input int i);
        case (i)
            0: return 16;
            1: return 16;
            2: return 16;
            3: return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int cfgD(input int i);
        case (i)
            0: return 4;
            1: return 1;
            2: return 16;
            3: return 2;
            default: return 8;
        endcase
    endfunction

    for (genvar g = 0; g < 5; g++) begin : gCfg
        localparam int W = cfgW(g);
        localparam int D = cfgD(g);
        localparam int N = W / D;

        logic         rst, startIn, modeIn, crIn, ackIn;
        logic         readyOut, brw, ovfOut, doneOut;
        logic [W-1:0] aIn, bIn, diffOut;
        bit           started = 1'b0;
        bit           fin = 1'b0;

        addsub_serial #(
            .WIDTH (W),
            .DIGIT (D)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .startIn  (startIn),
            .modeIn   (modeIn),
            .aIn      (aIn),
            .bIn      (bIn),
            .crIn     (crIn),
            .readyOut (readyOut),
            .diffOut  (diffOut),
            .brw      (brw),
            .ovfOut   (ovfOut),
            .doneOut  (doneOut),
            .ackIn    (ackIn)
        );

        // Reference result: {result, carry/borrow, signed overflow}.
        function automatic logic [W+1:0] refCalc(input logic m, input logic [W-1:0] a,
                                                 input logic [W-1:0] b, input logic c);
            longint ua, ub, uc, sa, sb, r, full, maxS, minS;
            logic   brwV, ovfV;
            ua   = longint'(a);
            ub   = longint'(b);
            uc   = longint'(c);
            sa   = longint'($signed(a));
            sb   = longint'($signed(b));
            maxS = (longint'(1) <<< (W - 1)) - 1;
            minS = -(longint'(1) <<< (W - 1));
            if (m) begin
                full = ua + ub + uc;
                r    = sa + sb + uc;
                brwV = ((full >> W) & 1) != 0;
            end else begin
                full = ua - ub - uc;
                r    = sa - sb - uc;
                brwV = ua < (ub + uc);
            end
            ovfV = (r > maxS) || (r < minS);
            return {W'(full), brwV, ovfV};
        endfunction

        // Behavioural model: an accepted start yields the result N edges later.
        logic         mBusy, mDone, mBrw, mOvf, pBrw, pOvf;
        logic [W-1:0] mDiff, pDiff;
        int           mLeft;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                mBusy <= 1'b0;
                mDone <= 1'b0;
                mLeft <= 0;
                mDiff <= '0;
                mBrw  <= 1'b0;
                mOvf  <= 1'b0;
            end else if (mBusy) begin
                if (mLeft == 1) begin
                    mBusy <= 1'b0;
                    mDone <= 1'b1;
                    mDiff <= pDiff;
                    mBrw  <= pBrw;
                    mOvf  <= pOvf;
                end
                mLeft <= mLeft - 1;
            end else if (mDone) begin
                if (ackIn) mDone <= 1'b0;
            end else if (startIn) begin
                {pDiff, pBrw, pOvf} <= refCalc(modeIn, aIn, bIn, crIn);
                mBusy <= 1'b1;
                mLeft <= N;
            end
        end

        task automatic chk(input string name, input longint unsigned act,
                           input longint unsigned exp);
            checks++;
            if (act != exp) begin
                errors++;
                $display("FAIL cfg%0d(%0d/%0d) %s: got %0h expected %0h", g, W, D, name, act,
                         exp);
            end
        endtask

        always @(negedge clk) begin
            if (started) begin
                chk("cyc_ready", readyOut, !mBusy && !mDone);
                chk("cyc_done", doneOut, mDone);
                chk("cyc_diff", diffOut, mDiff);
                chk("cyc_brw", brw, mBrw);
                chk("cyc_ovf", ovfOut, mOvf);
            end
        end

        task automatic scramble();
            startIn = 1'($urandom);
            aIn     = W'($urandom);
            bIn     = W'($urandom);
            modeIn  = 1'($urandom);
            crIn    = 1'($urandom);
        endtask

        task automatic runOp(input logic m, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c, input int ackDly, input logic noise,
                             input logic lit, input logic [W-1:0] eD, input logic eB,
                             input logic eO);
            int n;
            @(negedge clk);
            n = 0;
            while (!readyOut && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk("ready_wait", readyOut, 1);
            modeIn  = m;
            aIn     = a;
            bIn     = b;
            crIn    = c;
            startIn = 1'b1;
            @(posedge clk);
            #1;
            startIn = 1'b0;
            n = 0;
            while (!doneOut && n < 200) begin
                if (noise) begin
                    scramble();
                    ackIn = 1'($urandom);
                end
                @(posedge clk);
                #1;
                n++;
            end
            ackIn   = 1'b0;
            startIn = 1'b0;
            chk("latency", n, N);
            if (lit) begin
                chk("res_diff", diffOut, eD);
                chk("res_brw", brw, eB);
                chk("res_ovf", ovfOut, eO);
            end
            repeat (ackDly) begin
                @(negedge clk);
                if (noise) scramble();
            end
            if (lit) begin
                chk("hold_done", doneOut, 1);
                chk("hold_diff", diffOut, eD);
            end
            @(negedge clk);
            ackIn   = 1'b1;
            startIn = noise;  // start together with ack must not launch an op
            @(negedge clk);
            ackIn   = 1'b0;
            startIn = 1'b0;
            chk("ack_done", doneOut, 0);
            chk("ack_ready", readyOut, 1);
        endtask

        initial begin
            logic [W-1:0] msb, maxPos, ones;
            msb     = W'(1) << (W - 1);
            maxPos  = msb - W'(1);
            ones    = '1;
            rst     = 1'b1;
            startIn = 1'b0;
            modeIn  = 1'b0;
            aIn     = '0;
            bIn     = '0;
            crIn    = 1'b0;
            ackIn   = 1'b0;
            @(negedge clk);
            started = 1'b1;
            chk("rst_ready", readyOut, 1);
            chk("rst_done", doneOut, 0);
            chk("rst_diff", diffOut, 0);
            rst = 1'b0;

            runOp(1'b0, W'(32'h1234), W'(32'h0234), 1'b0, 0, 1'b0, 1'b1, W'(32'h1000), 1'b0,
                  1'b0);
            runOp(1'b0, '0, W'(1), 1'b0, 0, 1'b0, 1'b1, ones, 1'b1, 1'b0);
            runOp(1'b0, msb, W'(1), 1'b0, 0, 1'b0, 1'b1, maxPos, 1'b0, 1'b1);
            runOp(1'b1, maxPos, W'(1), 1'b1, 0, 1'b0, 1'b1, msb | W'(1), 1'b0, 1'b1);
            runOp(1'b1, ones, W'(1), 1'b0, 0, 1'b0, 1'b1, '0, 1'b1, 1'b0);
            runOp(1'b1, W'(32'h00F0), W'(32'h000F), 1'b0, 5, 1'b1, 1'b1, W'(32'h00FF), 1'b0,
                  1'b0);

            // Reset two digits into an operation.
            @(negedge clk);
            modeIn  = 1'b0;
            aIn     = W'(32'h1234);
            bIn     = W'(32'h0001);
            crIn    = 1'b0;
            startIn = 1'b1;
            @(posedge clk);
            #1;
            startIn = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            chk("abort_done", doneOut, 0);
            chk("abort_diff", diffOut, 0);
            chk("abort_brw", brw, 0);
            chk("abort_ovf", ovfOut, 0);
            chk("abort_ready", readyOut, 1);
            @(negedge clk);
            #1;
            rst = 1'b0;
            runOp(1'b0, W'(5), W'(3), 1'b0, 0, 1'b0, 1'b1, W'(2), 1'b0, 1'b0);

            repeat (1000) begin
                runOp(1'($urandom), W'($urandom), W'($urandom), 1'($urandom),
                      int'($urandom_range(2, 0)), 1'($urandom), 1'b0, '0, 1'b0, 1'b0);
            end
            fin = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (t < 90000 && !(gCfg[0].fin && gCfg[1].fin && gCfg[2].fin && gCfg[3].fin &&
                              gCfg[4].fin)) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (t >= 90000) begin
            errors++;
            $display("FAIL timeout: got %0d cycles expected fewer than 90000", t);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, digit-serial add/subtract unit; the multi-cycle successor to the fixed 16-bit ripple subtractor.
- Processes DIGIT bits per clock, so area scales with DIGIT rather than WIDTH.
- Adds an add/subtract mode, a signed-overflow flag and a start/done/ack handshake.
- Sits in the ALU datapath as a slow arithmetic unit behind the opcode decoder.

Parameters:
- WIDTH, 16, operand and result width in bits.
- DIGIT, 4, bits processed per cycle. Must divide WIDTH and satisfy 1 <= DIGIT <= WIDTH. NDIG = WIDTH/DIGIT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- startIn  in  1  operation request; sampled only in IDLE.
- modeIn  in  1  0 = subtract (a-b-crIn), 1 = add (a+b+crIn).
- aIn  in  WIDTH  minuend / addend A.
- bIn  in  WIDTH  subtrahend / addend B.
- crIn  in  1  borrow-in (sub) or carry-in (add).
- readyOut  out  1  high in IDLE; start will be accepted.
- diffOut  out  WIDTH  result, registered.
- brw  out  1  borrow-out (sub) or carry-out (add), registered.
- ovfOut  out  1  signed overflow, registered.
- doneOut  out  1  result valid; held until ackIn.
- ackIn  in  1  consumer accepts the result; sampled only in DONE.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - diffOut=0, brw=0, ovfOut=0, doneOut=0, readyOut=1.
  - Digit counter, carry register and operand/result shift registers cleared.
  - Reset during RUN or DONE aborts the operation; no partial result is ever exposed.
- State machine (states IDLE, RUN, DONE):
  - IDLE: readyOut=1. On startIn=1 at an edge:
    - Latch aIn, bIn, modeIn, crIn.
    - carry register <= crIn; counter <= 0; go to RUN.
  - RUN: each cycle, the slice processes digit `counter` (bits counter*DIGIT .. +DIGIT-1).
    - Inputs: the low DIGIT bits of the A/B shift registers and the carry register.
    - Result digit shifts into the result register from the MSB end; A/B shift right by DIGIT; carry register updates.
    - At counter==NDIG-1:
      - diffOut <= full result; brw <= final carry/borrow.
      - ovfOut <= (carry/borrow into bit WIDTH-1) XOR (carry/borrow out of bit WIDTH-1).
      - doneOut <= 1; go to DONE.
  - DONE: doneOut=1; diffOut, brw and ovfOut stay stable.
    - On ackIn=1: doneOut <= 0 and go to IDLE; readyOut=1 from the next cycle.
- Latency and throughput:
  - If start is sampled at edge k, doneOut rises at edge k+NDIG.
  - Minimum start-to-start interval is NDIG+2 cycles (RUN, DONE with immediate ack, IDLE).
- Ignored inputs:
  - startIn in RUN/DONE is ignored (readyOut=0); it is not queued.
  - ackIn in IDLE/RUN is ignored.
  - ackIn and startIn high together in DONE: only the ack takes effect; start must be reasserted in IDLE.
- Output retention:
  - diffOut, brw and ovfOut hold the last result through IDLE and RUN.
  - They update only on the RUN->DONE transition.
- Subtract arithmetic:
  - diff = (a - b - crIn) mod 2^WIDTH.
  - brw=1 iff a < b + crIn (unsigned).
- Add arithmetic:
  - sum = (a + b + crIn) mod 2^WIDTH.
  - brw = carry-out.
- Input stability: aIn, bIn, modeIn and crIn may change freely after the start edge.
- DIGIT==WIDTH: NDIG=1, RUN lasts one cycle, latency 1.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Mode constants: MODE_SUB=1'b0, MODE_ADD=1'b1.
- One combinational sub-module, addsub_digit (parameter DIGIT), in a ripple-of-full-cells style.
  - Inputs: a, b, cIn, mode.
  - Outputs: result digit, cOut, and cMsb (the carry/borrow into the slice's top bit, used for ovfOut).
- The top module holds the FSM, counter, shift registers and output registers.

Test Plan:
1. WIDTH=16, DIGIT=4, sub, a=0x1234, b=0x0234, crIn=0 -> diffOut=0x1000, brw=0, ovfOut=0; doneOut rises exactly 4 edges after the start edge.
2. Sub, a=0x0000, b=0x0001, crIn=0 -> diffOut=0xFFFF, brw=1, ovfOut=0. Then sub, a=0x8000, b=0x0001 -> diffOut=0x7FFF, brw=0, ovfOut=1.
3. Add, a=0x7FFF, b=0x0001, crIn=1 -> diffOut=0x8001, brw=0, ovfOut=1. Add, a=0xFFFF, b=0x0001, crIn=0 -> diffOut=0x0000, brw=1, ovfOut=0.
4. Handshake:
   - Hold ackIn=0 for 5 cycles in DONE -> outputs stable, doneOut stays 1.
   - Pulse startIn during RUN and DONE -> ignored, result unchanged.
   - Assert ackIn -> doneOut=0 and readyOut=1 next cycle.
   - startIn+ackIn together in DONE -> no new operation begins.
5. Assert rst mid-RUN (after 2 digits) -> immediately doneOut=0, diffOut=0, brw=0, ovfOut=0, readyOut=1. A subsequent op (a=5, b=3, sub) -> diffOut=2.
6. Parameter sweep {16/1, 16/16, 8/2, 32/8}:
   - Latency equals NDIG in every configuration.
   - 1000 random ops per configuration (random mode, crIn) match the a±b±crIn reference model for diffOut, brw and ovfOut.
